// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if: requester, response and CORDIC core signals of the arbiter.
interface cordic_arbiter_if;
    logic       req0_valid, req0_ready, req0_mode;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_mode;
    logic [7:0] req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp_x, rsp_y;
    logic       rsp_err;
    logic       core_start, core_mode, core_reset;
    logic [7:0] core_in0, core_in1;
    logic [7:0] core_out0, core_out1;
    logic       core_done;
    logic       busy;

    modport slave (
        input  req0_valid, req0_mode, req0_a, req0_b,
        input  req1_valid, req1_mode, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, core_out0, core_out1, core_done,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_x, rsp_y, rsp_err,
        output core_start, core_mode, core_reset, core_in0, core_in1, busy
    );

    modport master (
        output req0_valid, req0_mode, req0_a, req0_b,
        output req1_valid, req1_mode, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, core_out0, core_out1, core_done,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_x, rsp_y, rsp_err,
        input  core_start, core_mode, core_reset, core_in0, core_in1, busy
    );
endinterface

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one CORDIC core between two requesters,
// with a WAIT timeout that resets the core and returns an error response.
module cordic_arbiter #(
    parameter int TIMEOUT = 32
) (
    input logic clka,
    input logic reset,
    cordic_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state_q, state_d;
    logic       last_gnt_q, last_gnt_d, owner_q, owner_d, mode_q, mode_d;
    logic       err_q, err_d, core_reset_q, core_reset_d;
    logic [7:0] a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d, cnt_q, cnt_d;
    logic       grant, accept, rsp_hs, timeout;

    // Contention goes to the requester not served last; otherwise whoever is valid.
    assign grant   = (bus.req0_valid && bus.req1_valid) ? ~last_gnt_q : bus.req1_valid;
    assign accept  = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign rsp_hs  = (state_q == RESP) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
    assign timeout = cnt_q == 8'(TIMEOUT - 1);

    assign bus.req0_ready = (state_q == IDLE) && !grant && bus.req0_valid;
    assign bus.req1_ready = (state_q == IDLE) && grant && bus.req1_valid;
    assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
    assign bus.rsp1_valid = (state_q == RESP) && owner_q;
    assign bus.rsp_x      = x_q;
    assign bus.rsp_y      = y_q;
    assign bus.rsp_err    = err_q;
    assign bus.core_start = state_q == ISSUE;
    assign bus.core_mode  = mode_q;
    assign bus.core_in0   = a_q;
    assign bus.core_in1   = b_q;
    assign bus.core_reset = core_reset_q;
    assign bus.busy       = state_q != IDLE;

    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        owner_d      = owner_q;
        mode_d       = mode_q;
        a_d          = a_q;
        b_d          = b_q;
        x_d          = x_q;
        y_d          = y_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        core_reset_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                mode_d     = grant ? bus.req1_mode : bus.req0_mode;
                a_d        = grant ? bus.req1_a : bus.req0_a;
                b_d        = grant ? bus.req1_b : bus.req0_b;
                owner_d    = grant;
                last_gnt_d = grant;
                state_d    = ISSUE;
            end
            ISSUE: begin
                cnt_d   = 8'd0;
                state_d = WAIT;
            end
            // A completion in the last allowed cycle still wins over the timeout.
            WAIT: if (bus.core_done) begin
                x_d     = bus.core_out0;
                y_d     = bus.core_out1;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (timeout) begin
                x_d          = 8'd0;
                y_d          = 8'd0;
                err_d        = 1'b1;
                core_reset_d = 1'b1;
                state_d      = RESP;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            RESP: if (rsp_hs) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q      <= IDLE;
            last_gnt_q   <= 1'b1;
            owner_q      <= 1'b0;
            mode_q       <= 1'b0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            err_q        <= 1'b0;
            cnt_q        <= 8'd0;
            core_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            owner_q      <= owner_d;
            mode_q       <= mode_d;
            a_q          <= a_d;
            b_q          <= b_d;
            x_q          <= x_d;
            y_q          <= y_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
        end
    end
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed checks of grant order, core handshake, timeout,
// response stall and mid-transaction reset.
module tb_cordic_arbiter;
    logic clka = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   start_cnt = 0;
    int   rsp1_cnt = 0;
    int   s0, r1;

    always #5 clka = ~clka;

    cordic_arbiter_if bus();
    cordic_arbiter #(.TIMEOUT(32)) dut (.clka(clka), .reset(reset), .bus(bus));

    always @(posedge clka) begin
        if (bus.core_start) start_cnt <= start_cnt + 1;
        if (bus.rsp1_valid) rsp1_cnt <= rsp1_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clka);
    endtask

    // Called in IDLE with the request(s) already driven; completes one transaction.
    task automatic serve(input bit who, input int lat, input bit issue_done, input bit drop,
                         input logic [7:0] o0, input logic [7:0] o1,
                         input logic [7:0] exp_in0, input bit exp_mode, input string tag);
        #1;
        chk({tag, "_rdy0"}, bus.req0_ready, !who);
        chk({tag, "_rdy1"}, bus.req1_ready, who);
        tick();
        if (drop) begin
            if (who) bus.req1_valid = 1'b0;
            else bus.req0_valid = 1'b0;
        end
        chk({tag, "_start"}, bus.core_start, 1);
        chk({tag, "_in0"}, bus.core_in0, exp_in0);
        chk({tag, "_mode"}, bus.core_mode, exp_mode);
        if (issue_done) begin
            bus.core_done = 1'b1;
            bus.core_out0 = 8'hEE;
            bus.core_out1 = 8'hEE;
        end
        tick();
        bus.core_done = 1'b0;
        chk({tag, "_start_off"}, bus.core_start, 0);
        chk({tag, "_wait_norsp"}, bus.rsp0_valid | bus.rsp1_valid, 0);
        repeat (lat - 1) tick();
        bus.core_done = 1'b1;
        bus.core_out0 = o0;
        bus.core_out1 = o1;
        tick();
        bus.core_done = 1'b0;
        chk({tag, "_vld_own"}, who ? bus.rsp1_valid : bus.rsp0_valid, 1);
        chk({tag, "_vld_oth"}, who ? bus.rsp0_valid : bus.rsp1_valid, 0);
        chk({tag, "_x"}, bus.rsp_x, o0);
        chk({tag, "_y"}, bus.rsp_y, o1);
        chk({tag, "_err"}, bus.rsp_err, 0);
        if (who) bus.rsp1_ready = 1'b1;
        else bus.rsp0_ready = 1'b1;
        tick();
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        chk({tag, "_idle"}, bus.busy, 0);
        chk({tag, "_vld_off"}, bus.rsp0_valid | bus.rsp1_valid, 0);
    endtask

    initial begin
        bus.req0_valid = 0; bus.req0_mode = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_mode = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        bus.core_out0 = 0; bus.core_out1 = 0; bus.core_done = 0;
        repeat (2) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_vld", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk("rst_xy", {bus.rsp_x, bus.rsp_y}, 0);
        chk("rst_err", bus.rsp_err, 0);
        chk("rst_core", {bus.core_start, bus.core_reset}, 0);
        reset = 1'b0;

        // Continuous contention: 0 first after reset, then alternating.
        bus.req0_valid = 1; bus.req0_mode = 1; bus.req0_a = 8'h20; bus.req0_b = 8'h30;
        bus.req1_valid = 1; bus.req1_mode = 0; bus.req1_a = 8'h21; bus.req1_b = 8'h31;
        serve(0, 2, 0, 0, 8'h11, 8'h12, 8'h20, 1, "c0");
        serve(1, 3, 0, 0, 8'h13, 8'h14, 8'h21, 0, "c1");
        serve(0, 1, 0, 0, 8'h15, 8'h16, 8'h20, 1, "c2");
        serve(1, 2, 0, 1, 8'h17, 8'h18, 8'h21, 0, "c3");
        bus.req0_valid = 0;

        // Single req0, core done 4 cycles after start.
        s0 = start_cnt; r1 = rsp1_cnt;
        bus.req0_valid = 1; bus.req0_mode = 0; bus.req0_a = 8'd10; bus.req0_b = 8'd0;
        serve(0, 4, 0, 1, 8'h0A, 8'h00, 8'h0A, 0, "t1");
        chk("t1_start_pulses", start_cnt - s0, 1);
        chk("t1_no_rsp1", rsp1_cnt - r1, 0);

        // Done during ISSUE must be ignored.
        bus.req1_valid = 1; bus.req1_mode = 1; bus.req1_a = 8'h33; bus.req1_b = 8'h03;
        serve(1, 4, 1, 1, 8'h55, 8'h66, 8'h33, 1, "t36");

        // Timeout: exactly 32 WAIT cycles then error response.
        bus.req0_valid = 1; bus.req0_a = 8'h44;
        tick();
        bus.req0_valid = 0;
        tick();
        repeat (31) tick();
        chk("to_busy", bus.busy, 1);
        chk("to_early", bus.rsp0_valid, 0);
        chk("to_creset_early", bus.core_reset, 0);
        chk("to_in0_hold", bus.core_in0, 8'h44);
        tick();
        chk("to_creset", bus.core_reset, 1);
        chk("to_vld", bus.rsp0_valid, 1);
        chk("to_err", bus.rsp_err, 1);
        chk("to_xy", {bus.rsp_x, bus.rsp_y}, 0);
        tick();
        chk("to_creset_off", bus.core_reset, 0);
        chk("to_vld_hold", bus.rsp0_valid, 1);
        bus.rsp0_ready = 1;
        tick();
        bus.rsp0_ready = 0;
        chk("to_idle", bus.busy, 0);

        // Done in the final allowed cycle beats timeout.
        bus.req1_valid = 1; bus.req1_a = 8'h45;
        tick();
        bus.req1_valid = 0;
        tick();
        repeat (31) tick();
        bus.core_done = 1; bus.core_out0 = 8'h77; bus.core_out1 = 8'h88;
        tick();
        bus.core_done = 0;
        chk("pri_vld", bus.rsp1_valid, 1);
        chk("pri_err", bus.rsp_err, 0);
        chk("pri_xy", {bus.rsp_x, bus.rsp_y}, 16'h7788);
        chk("pri_creset", bus.core_reset, 0);

        // Stalled response: pending req0 and stray rsp0_ready must not disturb it.
        bus.req0_valid = 1; bus.req0_a = 8'h46; bus.req0_mode = 0; bus.rsp0_ready = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_vld", bus.rsp1_valid, 1);
            chk("stall_xy", {bus.rsp_x, bus.rsp_y}, 16'h7788);
            chk("stall_nogrant", bus.req0_ready, 0);
        end
        bus.rsp0_ready = 0; bus.rsp1_ready = 1;
        tick();
        bus.rsp1_ready = 0;
        serve(0, 1, 0, 1, 8'h9A, 8'h9B, 8'h46, 0, "t34");

        // Reset during WAIT abandons the transaction.
        bus.req0_valid = 1; bus.req0_a = 8'h5A;
        tick();
        bus.req0_valid = 0;
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("mr_busy", bus.busy, 0);
        chk("mr_in0", bus.core_in0, 0);
        chk("mr_xy", {bus.rsp_x, bus.rsp_y}, 0);
        chk("mr_vld", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk("mr_core", {bus.core_start, bus.core_reset, bus.rsp_err}, 0);
        bus.core_done = 1; bus.core_out0 = 8'h99;
        tick();
        bus.core_done = 0;
        chk("mr_norsp", {bus.rsp0_valid, bus.busy}, 0);
        bus.req1_valid = 1; bus.req1_a = 8'h6B; bus.req1_mode = 1;
        serve(1, 2, 0, 1, 8'hA1, 8'hA2, 8'h6B, 1, "t35");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
